// File: rtl/vga_timing_gen_p.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_p
//   Parametrised raster timing generator for frame-buffer / ROM video paths.
//   Free-running H/V counters produce a linear read address for the pixel
//   memory. Sync, data-enable, raster position and frame markers travel
//   through a delay pipe whose length matches the memory read latency (LAT),
//   so they reach the outputs together with the returned pixel data.
//   The source image may be smaller than the raster by a power of two
//   (SCALE_SH); the address then repeats each source pixel/line.
//
// Ports
//   clk        in   1       clock
//   reset      in   1       synchronous, active-high reset (wins over pix_en)
//   pix_en     in   1       pixel strobe; all state advances only when 1
//   addr_o     out  ADDR_W  frame-buffer read address (registered)
//   addr_valid out  1       addr_o is an active-area fetch
//   h_sync     out  1       horizontal sync, level HS_POL when active
//   v_sync     out  1       vertical sync, level VS_POL when active
//   de         out  1       data enable, aligned with read data
//   x_pixel    out  CNT_W   horizontal position incl. blanking, aligned
//   y_pixel    out  CNT_W   vertical position incl. blanking, aligned
//   sof        out  1       first active pixel of a frame
//   eol        out  1       last active pixel of each active line
//   frame_cnt  out  16      completed-frame counter (not pipelined)
// ---------------------------------------------------------------------------
module vga_timing_gen_p #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int LAT      = 1,
    parameter int SCALE_SH = 0,
    parameter int CNT_W    = 10,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid,
    output logic              h_sync,
    output logic              v_sync,
    output logic              de,
    output logic [CNT_W-1:0]  x_pixel,
    output logic [CNT_W-1:0]  y_pixel,
    output logic              sof,
    output logic              eol,
    output logic [15:0]       frame_cnt
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_EOL      = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Width of one source line in the frame buffer.
    localparam logic [ADDR_W-1:0] SRC_W = ADDR_W'(H_ACTIVE >> SCALE_SH);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Everything that must stay aligned with the returned pixel data.
    typedef struct packed {
        logic             act;
        logic             hs;
        logic             vs;
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] v;
        logic             sof;
        logic             eol;
    } pipe_t;

    logic [CNT_W-1:0]  r_h;
    logic [CNT_W-1:0]  r_v;
    logic [15:0]       r_frame_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_addr_valid;
    pipe_t             r_pipe [0:LAT];

    logic              w_h_wrap;
    logic              w_v_wrap;
    pipe_t             w_stage0;
    logic [ADDR_W-1:0] w_addr;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);

    // Raster counters and frame counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
        end else if (pix_en) begin
            if (w_h_wrap) begin
                r_h <= '0;
                if (w_v_wrap) begin
                    r_v         <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_v <= r_v + CNT_W'(1);
                end
            end else begin
                r_h <= r_h + CNT_W'(1);
            end
        end
    end

    // Stage-0 decode of the current raster position and its fetch address.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a value unassigned (no latch).
        w_addr       = '0;
        w_stage0.act = (r_h < H_ACT) && (r_v < V_ACT);
        w_stage0.hs  = (r_h >= H_SYNC_ON) && (r_h < H_SYNC_OFF);
        w_stage0.vs  = (r_v >= V_SYNC_ON) && (r_v < V_SYNC_OFF);
        w_stage0.h   = r_h;
        w_stage0.v   = r_v;
        w_stage0.sof = (r_h == '0) && (r_v == '0);
        w_stage0.eol = (r_h == H_EOL) && (r_v < V_ACT);
        if (w_stage0.act) begin
            w_addr = ADDR_W'(r_v >> SCALE_SH) * SRC_W + ADDR_W'(r_h >> SCALE_SH);
        end
    end

    // Address register plus the latency-matching pipe. Stage 0 is loaded in
    // the same strobe as addr_o; stage LAT drives the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_addr_valid <= 1'b0;
            // NOTE: the pipe array is reset explicitly: after a mid-frame
            // reset any stale de/sof/eol still in flight must be discarded.
            for (int i = 0; i <= LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (pix_en) begin
            r_addr       <= w_addr;
            r_addr_valid <= w_stage0.act;
            r_pipe[0]    <= w_stage0;
            for (int i = 1; i <= LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign addr_o     = r_addr;
    assign addr_valid = r_addr_valid;
    assign de         = r_pipe[LAT].act;
    assign x_pixel    = r_pipe[LAT].h;
    assign y_pixel    = r_pipe[LAT].v;
    assign sof        = r_pipe[LAT].sof;
    assign eol        = r_pipe[LAT].eol;
    assign h_sync     = r_pipe[LAT].hs ? HS_ON : ~HS_ON;
    assign v_sync     = r_pipe[LAT].vs ? VS_ON : ~VS_ON;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen_p
//   Three instances share clk/reset/pix_en:
//     u_def : all default parameters (640x480, active-low syncs, LAT=1)
//     u_a   : small raster, active-low syncs, LAT=1, no scaling
//     u_b   : small raster, active-high syncs, LAT=3, SCALE_SH=1
//   The reference model derives every output from the number of pixel
//   strobes seen since reset release: the raster position of a strobe index
//   is plain div/mod arithmetic on the line and frame totals.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen_p;

    typedef struct packed {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int hpol, vpol, lat, sh;
    } cfg_t;

    typedef struct packed {
        int addr, av, hs, vs, de, x, y, sof, eol, fc;
    } exp_t;

    // Small raster: 24 x 12 totals, 288 strobes per frame.
    localparam int S_HA = 16, S_HFP = 2, S_HSW = 3, S_HBP = 3;
    localparam int S_VA = 8,  S_VFP = 1, S_VSW = 2, S_VBP = 1;

    localparam cfg_t CFG_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1, 0};
    localparam cfg_t CFG_A   = '{S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 0, 0, 1, 0};
    localparam cfg_t CFG_B   = '{S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 1, 1, 3, 1};

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    always #5 clk = ~clk;

    logic [18:0] d_addr, a_addr, b_addr;
    logic        d_av, a_av, b_av;
    logic        d_hs, a_hs, b_hs;
    logic        d_vs, a_vs, b_vs;
    logic        d_de, a_de, b_de;
    logic [9:0]  d_x, a_x, b_x;
    logic [9:0]  d_y, a_y, b_y;
    logic        d_sof, a_sof, b_sof;
    logic        d_eol, a_eol, b_eol;
    logic [15:0] d_fc, a_fc, b_fc;

    vga_timing_gen_p u_def (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .addr_o(d_addr), .addr_valid(d_av), .h_sync(d_hs), .v_sync(d_vs),
        .de(d_de), .x_pixel(d_x), .y_pixel(d_y), .sof(d_sof), .eol(d_eol),
        .frame_cnt(d_fc)
    );

    vga_timing_gen_p #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .HS_POL(0), .VS_POL(0), .LAT(1), .SCALE_SH(0)
    ) u_a (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .addr_o(a_addr), .addr_valid(a_av), .h_sync(a_hs), .v_sync(a_vs),
        .de(a_de), .x_pixel(a_x), .y_pixel(a_y), .sof(a_sof), .eol(a_eol),
        .frame_cnt(a_fc)
    );

    vga_timing_gen_p #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
        .HS_POL(1), .VS_POL(1), .LAT(3), .SCALE_SH(1)
    ) u_b (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .addr_o(b_addr), .addr_valid(b_av), .h_sync(b_hs), .v_sync(b_vs),
        .de(b_de), .x_pixel(b_x), .y_pixel(b_y), .sof(b_sof), .eol(b_eol),
        .frame_cnt(b_fc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;     // pixel strobes since reset release
    bit armed    = 1'b0;  // set once a reset edge has been applied

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t n=%0d: got %0d, expected %0d", name, $time, n, act, exp);
        end
    endtask

    // Expected outputs after n strobes since reset release.
    function automatic exp_t model(input cfg_t c, input int strobes);
        exp_t e;
        int htot, vtot, p, h, v;
        htot = c.ha + c.hfp + c.hsw + c.hbp;
        vtot = c.va + c.vfp + c.vsw + c.vbp;
        e = '0;
        e.hs = 1 - c.hpol;
        e.vs = 1 - c.vpol;
        e.fc = (strobes / (htot * vtot)) % 65536;
        if (strobes >= 1) begin
            p = strobes - 1;
            h = p % htot;
            v = (p / htot) % vtot;
            if (h < c.ha && v < c.va) begin
                e.av   = 1;
                e.addr = (v >> c.sh) * (c.ha >> c.sh) + (h >> c.sh);
            end
        end
        if (strobes >= 1 + c.lat) begin
            p = strobes - 1 - c.lat;
            h = p % htot;
            v = (p / htot) % vtot;
            e.de  = (h < c.ha && v < c.va) ? 1 : 0;
            e.x   = h;
            e.y   = v;
            e.sof = (h == 0 && v == 0) ? 1 : 0;
            e.eol = (h == c.ha - 1 && v < c.va) ? 1 : 0;
            if (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) e.hs = c.hpol;
            if (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) e.vs = c.vpol;
        end
        return e;
    endfunction

    task automatic check_inst(input string tag, input exp_t e,
                              input logic [31:0] addr, input logic [31:0] av,
                              input logic [31:0] hs,   input logic [31:0] vs,
                              input logic [31:0] de,   input logic [31:0] x,
                              input logic [31:0] y,    input logic [31:0] sf,
                              input logic [31:0] el,   input logic [31:0] fc);
        check({tag, "_addr"},  addr, e.addr);
        check({tag, "_avld"},  av,   e.av);
        check({tag, "_hsync"}, hs,   e.hs);
        check({tag, "_vsync"}, vs,   e.vs);
        check({tag, "_de"},    de,   e.de);
        check({tag, "_x"},     x,    e.x);
        check({tag, "_y"},     y,    e.y);
        check({tag, "_sof"},   sf,   e.sof);
        check({tag, "_eol"},   el,   e.eol);
        check({tag, "_fcnt"},  fc,   e.fc);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            n     <= 0;
            armed <= 1'b1;
        end else if (pix_en) begin
            n <= n + 1;
        end
    end

    // Compare process: every cycle once reset has been seen, plus literal
    // expectations at fixed strobe counts that pin the model.
    always @(negedge clk) begin
        if (armed) begin
            check_inst("def", model(CFG_DEF, n), 32'(d_addr), 32'(d_av), 32'(d_hs), 32'(d_vs),
                       32'(d_de), 32'(d_x), 32'(d_y), 32'(d_sof), 32'(d_eol), 32'(d_fc));
            check_inst("a", model(CFG_A, n), 32'(a_addr), 32'(a_av), 32'(a_hs), 32'(a_vs),
                       32'(a_de), 32'(a_x), 32'(a_y), 32'(a_sof), 32'(a_eol), 32'(a_fc));
            check_inst("b", model(CFG_B, n), 32'(b_addr), 32'(b_av), 32'(b_hs), 32'(b_vs),
                       32'(b_de), 32'(b_x), 32'(b_y), 32'(b_sof), 32'(b_eol), 32'(b_fc));

            case (n)
                1: begin
                    check("lit_def_avld_first", 32'(d_av), 32'd1);
                    check("lit_def_addr_first", 32'(d_addr), 32'd0);
                    check("lit_def_de_early",   32'(d_de), 32'd0);
                end
                2: begin
                    check("lit_def_de_first",  32'(d_de), 32'd1);
                    check("lit_def_sof_first", 32'(d_sof), 32'd1);
                    check("lit_def_x_first",   32'(d_x), 32'd0);
                    check("lit_def_y_first",   32'(d_y), 32'd0);
                end
                3:   check("lit_b_de_before_rise", 32'(b_de), 32'd0);
                4: begin
                    check("lit_b_de_rise", 32'(b_de), 32'd1);
                    check("lit_b_sof",     32'(b_sof), 32'd1);
                end
                17: begin
                    check("lit_b_blank_addr", 32'(b_addr), 32'd0);
                    check("lit_b_blank_avld", 32'(b_av), 32'd0);
                end
                21:  check("lit_b_hs_before", 32'(b_hs), 32'd0);
                22:  check("lit_b_hs_start",  32'(b_hs), 32'd1);
                78:  check("lit_b_addr_5_3",  32'(b_addr), 32'd10);
                184: check("lit_b_addr_last", 32'(b_addr), 32'd31);
                287: check("lit_a_fcnt_0", 32'(a_fc), 32'd0);
                288: check("lit_a_fcnt_1", 32'(a_fc), 32'd1);
                576: check("lit_a_fcnt_2", 32'(a_fc), 32'd2);
                640: check("lit_def_addr_639", 32'(d_addr), 32'd639);
                641: begin
                    check("lit_def_eol",   32'(d_eol), 32'd1);
                    check("lit_def_eol_x", 32'(d_x), 32'd639);
                end
                657: check("lit_def_hs_655", 32'(d_hs), 32'd1);
                658: check("lit_def_hs_656", 32'(d_hs), 32'd0);
                753: check("lit_def_hs_751", 32'(d_hs), 32'd0);
                754: check("lit_def_hs_752", 32'(d_hs), 32'd1);
                default: ;
            endcase
        end
    end

    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;
        repeat (3) @(negedge clk);

        // Continuous strobes: two small frames and the first default line.
        reset  = 1'b0;
        pix_en = 1'b1;
        repeat (900) @(negedge clk);

        // pix_en toggling every clock.
        for (int i = 0; i < 600; i++) begin
            pix_en = ~pix_en;
            @(negedge clk);
        end

        // Mid-frame reset for one clock.
        pix_en = 1'b1;
        repeat (137) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_def_de",    32'(d_de), 32'd0);
        check("rst_def_hsync", 32'(d_hs), 32'd1);
        check("rst_def_vsync", 32'(d_vs), 32'd1);
        check("rst_b_hsync",   32'(b_hs), 32'd0);
        check("rst_b_vsync",   32'(b_vs), 32'd0);
        check("rst_a_fcnt",    32'(a_fc), 32'd0);
        check("rst_b_sof",     32'(b_sof), 32'd0);
        reset = 1'b0;

        // Randomised pixel strobe with occasional resets.
        for (int i = 0; i < 20000; i++) begin
            pix_en = ($urandom_range(0, 3) != 0);
            reset  = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        reset  = 1'b0;
        pix_en = 1'b1;
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
